// File: rtl/vgather.sv
// Packs a scalar element stream into zero-padded vectors for the reduce tree.
// One fill buffer plus one output register; sum_valid tracks tree depth.
module vgather #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16,
  parameter int LATENCY     = $clog2(VECTOR_SIZE)
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INT_SIZE-1:0]                  in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] out_vec,
  output logic [$clog2(VECTOR_SIZE):0]         out_count,
  output logic                                 sum_valid
);
  localparam int IW = $clog2(VECTOR_SIZE);
  localparam int CW = IW + 1;

  typedef logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] vec_t;

  vec_t          fbuf_q, fbuf_d;
  vec_t          ovec_q, ovec_d;
  vec_t          merged;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic [CW-1:0] cnt;
  logic          full_q, full_d;
  logic          ov_q, ov_d;
  logic          acc, done, free, fire;

  // Lanes at or beyond the real count read zero, never stale buffer data.
  function automatic vec_t pad(vec_t v, logic [CW-1:0] n);
    vec_t r;
    for (int k = 0; k < VECTOR_SIZE; k++)
      r[k] = (CW'(k) < n) ? v[k] : '0;
    return r;
  endfunction

  assign in_ready  = !full_q;
  assign acc       = in_valid && !full_q;
  assign fire      = ov_q && out_ready;
  assign free      = !ov_q || out_ready;
  assign done      = acc && (in_last || idx_q == IW'(VECTOR_SIZE-1));
  assign cnt       = {1'b0, idx_q} + CW'(1);
  assign out_valid = ov_q;
  assign out_vec   = ovec_q;
  assign out_count = ocnt_q;

  always_comb begin
    merged        = fbuf_q;
    merged[idx_q] = in_data;
    fbuf_d        = acc ? merged : fbuf_q;
    idx_d         = idx_q;
    if (acc)
      idx_d = done ? '0 : idx_q + IW'(1);
    full_d = full_q;
    pcnt_d = pcnt_q;
    ov_d   = ov_q;
    ovec_d = ovec_q;
    ocnt_d = ocnt_q;
    unique case (1'b1)
      full_q && free: begin
        ovec_d = pad(fbuf_q, pcnt_q);
        ocnt_d = pcnt_q;
        ov_d   = 1'b1;
        full_d = 1'b0;
      end
      done && free: begin
        ovec_d = pad(merged, cnt);
        ocnt_d = cnt;
        ov_d   = 1'b1;
      end
      done && !free: begin
        pcnt_d = cnt;
        full_d = 1'b1;
      end
      fire && !done && !full_q: begin
        ov_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fbuf_q <= '0;
      idx_q  <= '0;
      pcnt_q <= '0;
      full_q <= 1'b0;
      ov_q   <= 1'b0;
      ovec_q <= '0;
      ocnt_q <= '0;
    end else begin
      fbuf_q <= fbuf_d;
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      full_q <= full_d;
      ov_q   <= ov_d;
      ovec_q <= ovec_d;
      ocnt_q <= ocnt_d;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign sum_valid = fire;
    end else begin : g_pipe
      localparam int PW = LATENCY;
      logic [PW-1:0] pipe_q;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
          pipe_q <= '0;
        else
          pipe_q <= PW'({pipe_q, fire});
      end
      assign sum_valid = pipe_q[PW-1];
    end
  endgenerate

endmodule

// File: tb/tb_vgather.sv
// Bench for vgather: directed scenarios plus random traffic against
// a queue-based model of vectors, occupancy and tree timing.
module tb_vgather;
  localparam int VS  = 16;
  localparam int IW  = 16;
  localparam int LAT = 4;
  localparam int VW  = VS * IW;

  typedef logic [VS-1:0][IW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    int   cnt;
  } exp_t;

  logic          clock = 0;
  logic          resetn = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 0;
  vec_t          out_vec;
  logic [4:0]    out_count;
  logic          sum_valid;

  vgather #(
    .VECTOR_SIZE(VS),
    .INT_SIZE(IW),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec(out_vec),
    .out_count(out_count),
    .sum_valid(sum_valid)
  );

  always #5 clock = ~clock;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int        cyc = 0;
  int        pending = 0;
  int        last_tree = 0;
  logic [IW-1:0] partial[$];
  exp_t      expq[$];
  bit        svexp[int];
  int        sums[int];
  int        sv_times[$];

  always @(negedge clock) begin
    exp_t e;
    int   s;
    cyc++;
    if (!resetn) begin
      partial.delete();
      expq.delete();
      svexp.delete();
      sums.delete();
      pending = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum_valid", sum_valid, 0);
    end else begin
      chk("in_ready", in_ready, pending < 2);
      chk("out_valid", out_valid, pending > 0);
      if (sum_valid || svexp.exists(cyc)) begin
        chk("sum_valid", sum_valid, svexp.exists(cyc));
        if (sum_valid) begin
          sv_times.push_back(cyc);
          if (sums.exists(cyc)) last_tree = sums[cyc];
        end
        svexp.delete(cyc);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("out_vec", out_vec, e.vec);
          chk("out_count", out_count, e.cnt);
        end
        s = 0;
        for (int k = 0; k < VS; k++) s += int'(out_vec[k]);
        svexp[cyc + LAT] = 1;
        sums[cyc + LAT] = s;
        pending--;
      end
      if (in_valid && in_ready) begin
        partial.push_back(in_data);
        if (partial.size() == VS || in_last) begin
          e.vec = '0;
          for (int k = 0; k < partial.size(); k++) e.vec[k] = partial[k];
          e.cnt = partial.size();
          expq.push_back(e);
          pending++;
          partial.delete();
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    int n;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_data  = IW'($urandom);
    in_last  = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  bit rnd_done = 0;
  int t0;

  initial begin
    resetn = 0;
    repeat (3) @(posedge clock);
    #1 resetn = 1;
    idle(2);

    // full vector 1..16
    out_ready = 1;
    last_tree = 0;
    for (int i = 1; i <= 16; i++) send(IW'(i), i == 16);
    @(negedge clock);
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_count", out_count, 16);
    chk("t1_lane0", out_vec[0], 1);
    chk("t1_lane15", out_vec[15], 16);
    idle(6);
    chk("t1_tree_sum", last_tree, 136);

    // padding after an all-ones vector
    for (int i = 0; i < 16; i++) send(16'hFFFF, 0);
    send(16'd4, 0);
    send(16'd6, 1);
    @(negedge clock);
    chk("t2_lane0", out_vec[0], 4);
    chk("t2_lane1", out_vec[1], 6);
    chk("t2_lane2", out_vec[2], 0);
    chk("t2_lane15", out_vec[15], 0);
    chk("t2_count", out_count, 2);
    idle(6);

    // backpressure: A on output, B parked
    out_ready = 0;
    for (int i = 0; i < 16; i++) send(IW'(16'h100 + i), 0);
    for (int i = 0; i < 16; i++) send(IW'(16'h200 + i), 0);
    @(negedge clock);
    chk("t3_parked_ready", in_ready, 0);
    chk("t3_a_lane0", out_vec[0], 16'h100);
    @(posedge clock);
    #1 out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
    @(negedge clock);
    chk("t3_b_lane0", out_vec[0], 16'h200);
    chk("t3_b_lane15", out_vec[15], 16'h20F);
    chk("t3_ready_back", in_ready, 1);
    chk("t3_valid", out_valid, 1);
    idle(1);
    out_ready = 1;
    idle(8);

    // sustained throughput
    sv_times.delete();
    t0 = cyc;
    for (int i = 0; i < 64; i++) send(IW'($urandom), 0);
    chk("t4_cycles", cyc - t0, 64);
    idle(10);
    chk("t4_pulses", sv_times.size(), 4);
    if (sv_times.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("t4_spacing", sv_times[i] - sv_times[i-1], 16);

    // reset mid-vector
    for (int i = 0; i < 7; i++) send(IW'(16'h55 + i), 0);
    resetn = 0;
    @(negedge clock);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", sum_valid, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    for (int i = 0; i < 16; i++) send(IW'(100 + i), 0);
    @(negedge clock);
    chk("t5_lane0", out_vec[0], 100);
    chk("t5_lane7", out_vec[7], 107);
    chk("t5_count", out_count, 16);
    idle(6);

    // gapped input, short vector of 3
    send(16'h11, 0);
    idle(1);
    send(16'h22, 0);
    idle(1);
    send(16'h33, 1);
    @(negedge clock);
    chk("t6_count", out_count, 3);
    chk("t6_lane0", out_vec[0], 16'h11);
    chk("t6_lane1", out_vec[1], 16'h22);
    chk("t6_lane2", out_vec[2], 16'h33);
    chk("t6_lane3", out_vec[3], 0);
    idle(6);

    // random traffic against the model
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send(IW'($urandom), $urandom_range(0, 7) == 0);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1 out_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    send(IW'($urandom), 1);
    out_ready = 1;
    idle(12);
    chk("drain_empty", expq.size(), 0);
    chk("drain_sums", svexp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
